store_write_buffer: RTL and testbench

- Posted-store buffer placed directly upstream of the single-cycle data memory, between the datapath's load/store path and the memory's single address port.
- Stores enter an in-order FIFO and retire to memory one per cycle whenever the memory port is free.
- Loads take priority on the memory port and get the youngest buffered data for a matching address, so program order is preserved.

---
 rtl/sb_pkg.sv | 16 +
 rtl/store_buffer_entry_array.sv | 67 ++++++
 rtl/store_write_buffer.sv | 119 +++++++++++
 tb/tb_store_write_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and default sizing for the posted-store write buffer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sb_pkg;
   localparam int WL           = 32;
   localparam int MEMORY_WIDTH = 32;
   localparam int SB_DEPTH     = 4;
   localparam int SB_PTR_W     = $clog2(SB_DEPTH);

   // One buffered store; field widths follow the package defaults.
   typedef struct packed {
      logic                    valid;
      logic [WL-1:0]           addr;
      logic [MEMORY_WIDTH-1:0] data;
   } sb_entry_t;
endpackage

// File: rtl/store_buffer_entry_array.sv
// Entry storage for the write buffer plus youngest-match address search.
// Latency: push/pop take effect on the next posedge; search result is combinational.
// Backpressure: none here; the parent only pushes when a slot is free. Macro: STORE_BUFFER_FWD_EN adds match data.
module store_buffer_entry_array #(
   parameter int WL           = sb_pkg::WL,
   parameter int MEMORY_WIDTH = sb_pkg::MEMORY_WIDTH,
   parameter int SB_DEPTH     = sb_pkg::SB_DEPTH,
   parameter int PTR_W        = $clog2(SB_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [PTR_W-1:0]        push_idx,
   input  logic [WL-1:0]           push_addr,
   input  logic [MEMORY_WIDTH-1:0] push_data,
   input  logic                    pop,
   input  logic [PTR_W-1:0]        head_idx,
   input  logic [WL-1:0]           lookup_addr,
   output logic [WL-1:0]           head_addr,
   output logic [MEMORY_WIDTH-1:0] head_data,
`ifdef STORE_BUFFER_FWD_EN
   output logic [MEMORY_WIDTH-1:0] match_data,
`endif
   output logic                    match
);
   import sb_pkg::*;

   sb_entry_t entries [SB_DEPTH];

   // Pop clears the head slot first so that a push into the same slot (full buffer) wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         if (pop) begin
            entries[head_idx].valid <= 1'b0;
         end
         if (push) begin
            entries[push_idx] <= '{valid: 1'b1, addr: push_addr, data: push_data};
         end
      end
   end

   assign head_addr = entries[head_idx].addr;
   assign head_data = entries[head_idx].data;

   // Walk slots oldest-to-youngest from the head; a later hit overrides, so the youngest wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx   = head_idx;
      match = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
      match_data = '0;
`endif
      for (int i = 0; i < SB_DEPTH; i++) begin
         idx = head_idx + PTR_W'(i);
         if (entries[idx].valid && (entries[idx].addr == lookup_addr)) begin
            match = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
            match_data = entries[idx].data;
`endif
         end
      end
   end
endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO in front of a single-port data memory; loads win the port, stores drain when it is free.
// Latency: store reaches memory >= 1 cycle after acceptance; load data is combinational in the same cycle.
// Backpressure: CPU_Stall when full with the port held by a load; without STORE_BUFFER_FWD_EN also on a load hitting a buffered address.
module store_write_buffer #(
   parameter int WL           = sb_pkg::WL,
   parameter int MEMORY_WIDTH = sb_pkg::MEMORY_WIDTH,
   parameter int SB_DEPTH     = sb_pkg::SB_DEPTH
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         CPU_Store_Req,
   input  logic [WL-1:0]                CPU_Store_Addr,
   input  logic [MEMORY_WIDTH-1:0]      CPU_Store_Data,
   input  logic                         CPU_Load_Req,
   input  logic [WL-1:0]                CPU_Load_Addr,
   output logic [MEMORY_WIDTH-1:0]      CPU_Load_Data,
   output logic                         CPU_Stall,
   output logic [WL-1:0]                DM_Input_Address,
   output logic [MEMORY_WIDTH-1:0]      DM_Data_To_Write,
   output logic                         DM_Write_Enable_Flag,
   input  logic [MEMORY_WIDTH-1:0]      DM_Output_Data,
   output logic                         SB_Empty,
   output logic [$clog2(SB_DEPTH):0]    SB_Count
);
   import sb_pkg::*;

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(SB_DEPTH);

   logic [PTR_W-1:0]        head_ptr;
   logic [PTR_W-1:0]        tail_ptr;
   logic [CNT_W-1:0]        count;
   logic                    full;
   logic                    hit;
   logic                    hazard;
   logic                    load_grant;
   logic                    drain;
   logic                    store_block;
   logic                    push;
   logic [WL-1:0]           head_addr;
   logic [MEMORY_WIDTH-1:0] head_data;
`ifdef STORE_BUFFER_FWD_EN
   logic [MEMORY_WIDTH-1:0] hit_data;
`endif

   assign full     = (count == FULL_COUNT);
   assign SB_Empty = (count == '0);
   assign SB_Count = count;

   store_buffer_entry_array #(
      .WL           (WL),
      .MEMORY_WIDTH (MEMORY_WIDTH),
      .SB_DEPTH     (SB_DEPTH),
      .PTR_W        (PTR_W)
   ) u_entries (
      .clk         (CLK),
      .rst         (RST),
      .push        (push),
      .push_idx    (tail_ptr),
      .push_addr   (CPU_Store_Addr),
      .push_data   (CPU_Store_Data),
      .pop         (drain),
      .head_idx    (head_ptr),
      .lookup_addr (CPU_Load_Addr),
      .head_addr   (head_addr),
      .head_data   (head_data),
`ifdef STORE_BUFFER_FWD_EN
      .match_data  (hit_data),
`endif
      .match       (hit)
   );

   // Port arbitration: a granted load owns the port, otherwise the head entry drains.
   always_comb begin
      hazard = 1'b0;
`ifndef STORE_BUFFER_FWD_EN
      // No forwarding path: a load hitting a buffered address waits and lets the drain run.
      hazard = CPU_Load_Req && hit;
`endif
      load_grant           = CPU_Load_Req && !hazard;
      drain                = !load_grant && (count != '0);
      store_block          = CPU_Store_Req && full && !drain;
      CPU_Stall            = hazard || store_block;
      push                 = CPU_Store_Req && !CPU_Stall;
      DM_Write_Enable_Flag = drain;
      DM_Input_Address     = drain ? head_addr : CPU_Load_Addr;
      DM_Data_To_Write     = head_data;
   end

   // Load result: youngest buffered copy when forwarding is built in, else straight from memory.
   always_comb begin
`ifdef STORE_BUFFER_FWD_EN
      CPU_Load_Data = hit ? hit_data : DM_Output_Data;
`else
      CPU_Load_Data = DM_Output_Data;
`endif
   end

   // Pointer and occupancy update; push and pop in one cycle cancel in the count.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            tail_ptr <= tail_ptr + PTR_W'(1);
         end
         if (drain) begin
            head_ptr <= head_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(drain);
      end
   end

   count_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(push && !drain && full));
   count_no_underflow: assert property (@(posedge CLK) disable iff (RST) !(drain && (count == '0)));
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with a behavioural single-cycle memory.
// Latency: checks outputs on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: retries stalled stores in the wrap-around sequence.
module tb_store_write_buffer;
   logic        CLK;
   logic        RST;
   logic        CPU_Store_Req;
   logic [31:0] CPU_Store_Addr;
   logic [31:0] CPU_Store_Data;
   logic        CPU_Load_Req;
   logic [31:0] CPU_Load_Addr;
   logic [31:0] CPU_Load_Data;
   logic        CPU_Stall;
   logic [31:0] DM_Input_Address;
   logic [31:0] DM_Data_To_Write;
   logic        DM_Write_Enable_Flag;
   logic [31:0] DM_Output_Data;
   logic        SB_Empty;
   logic [2:0]  SB_Count;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] mem [0:63];
   logic [63:0] exp_q [$];
   logic        sb_on = 1'b0;

   store_write_buffer dut (
      .CLK                  (CLK),
      .RST                  (RST),
      .CPU_Store_Req        (CPU_Store_Req),
      .CPU_Store_Addr       (CPU_Store_Addr),
      .CPU_Store_Data       (CPU_Store_Data),
      .CPU_Load_Req         (CPU_Load_Req),
      .CPU_Load_Addr        (CPU_Load_Addr),
      .CPU_Load_Data        (CPU_Load_Data),
      .CPU_Stall            (CPU_Stall),
      .DM_Input_Address     (DM_Input_Address),
      .DM_Data_To_Write     (DM_Data_To_Write),
      .DM_Write_Enable_Flag (DM_Write_Enable_Flag),
      .DM_Output_Data       (DM_Output_Data),
      .SB_Empty             (SB_Empty),
      .SB_Count             (SB_Count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Single-cycle memory: combinational read, write on the rising edge.
   assign DM_Output_Data = mem[DM_Input_Address[5:0]];
   always @(posedge CLK) begin
      if (DM_Write_Enable_Flag) mem[DM_Input_Address[5:0]] <= DM_Data_To_Write;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every memory write must be the oldest accepted, not-yet-written store.
   always @(negedge CLK) begin
      if (sb_on && !RST && DM_Write_Enable_Flag) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_write", DM_Input_Address, 32'hFFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("sb_write_addr", DM_Input_Address, e[63:32]);
            check("sb_write_data", DM_Data_To_Write, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic st; logic [31:0] sa; logic [31:0] sd;
      logic ld; logic [31:0] la;
      logic e_stall; logic e_we; logic [31:0] e_addr; int e_count; logic e_empty;
      logic [31:0] e_wdata; logic chk_ld; logic [31:0] e_ld;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic [31:0] sa, input logic [31:0] sd,
                               input logic ld, input logic [31:0] la,
                               input logic e_stall, input logic e_we, input logic [31:0] e_addr,
                               input int e_count, input logic e_empty, input logic [31:0] e_wdata,
                               input logic chk_ld, input logic [31:0] e_ld);
      vec_t v;
      v.st = st; v.sa = sa; v.sd = sd; v.ld = ld; v.la = la;
      v.e_stall = e_stall; v.e_we = e_we; v.e_addr = e_addr; v.e_count = e_count;
      v.e_empty = e_empty; v.e_wdata = e_wdata; v.chk_ld = chk_ld; v.e_ld = e_ld;
      return v;
   endfunction

   task automatic drive(input logic st, input logic [31:0] sa, input logic [31:0] sd,
                        input logic ld, input logic [31:0] la);
      CPU_Store_Req  = st;
      CPU_Store_Addr = sa;
      CPU_Store_Data = sd;
      CPU_Load_Req   = ld;
      CPU_Load_Addr  = la;
   endtask

   task automatic idle();
      drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   vec_t vt [17];
   int   max_cnt;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      RST = 1'b1;
      idle();

      // Basic drain, then fill under load pressure and full push+pop.
      vt[0]  = mk(0, 0,  0,            0, 0,  0, 0, 0,  0, 1, 0,            0, 0);
      vt[1]  = mk(1, 5,  32'hAAAA5555, 0, 0,  0, 0, 0,  0, 1, 0,            0, 0);
      vt[2]  = mk(0, 0,  0,            0, 0,  0, 1, 5,  1, 0, 32'hAAAA5555, 0, 0);
      vt[3]  = mk(0, 0,  0,            1, 5,  0, 0, 5,  0, 1, 0,            1, 32'hAAAA5555);
      vt[4]  = mk(1, 10, 32'h10,       1, 9,  0, 0, 9,  0, 1, 0,            1, 0);
      vt[5]  = mk(1, 11, 32'h11,       1, 9,  0, 0, 9,  1, 0, 0,            1, 0);
      vt[6]  = mk(1, 12, 32'h12,       1, 9,  0, 0, 9,  2, 0, 0,            1, 0);
      vt[7]  = mk(1, 13, 32'h13,       1, 9,  0, 0, 9,  3, 0, 0,            1, 0);
      vt[8]  = mk(1, 14, 32'h14,       1, 9,  1, 0, 9,  4, 0, 0,            1, 0);
      vt[9]  = mk(1, 14, 32'h14,       0, 0,  0, 1, 10, 4, 0, 32'h10,       0, 0);
      vt[10] = mk(0, 0,  0,            1, 20, 0, 0, 20, 4, 0, 0,            1, 0);
      vt[11] = mk(0, 0,  0,            0, 0,  0, 1, 11, 4, 0, 32'h11,       0, 0);
      vt[12] = mk(0, 0,  0,            0, 0,  0, 1, 12, 3, 0, 32'h12,       0, 0);
      vt[13] = mk(0, 0,  0,            0, 0,  0, 1, 13, 2, 0, 32'h13,       0, 0);
      vt[14] = mk(0, 0,  0,            0, 0,  0, 1, 14, 1, 0, 32'h14,       0, 0);
      vt[15] = mk(0, 0,  0,            0, 0,  0, 0, 0,  0, 1, 0,            0, 0);
      vt[16] = mk(0, 0,  0,            1, 14, 0, 0, 14, 0, 1, 0,            1, 32'h14);

      // Reset state while RST is held.
      #12;
      check("rst_empty", 32'(SB_Empty), 32'd1);
      check("rst_count", 32'(SB_Count), 32'd0);
      check("rst_we", 32'(DM_Write_Enable_Flag), 32'd0);
      check("rst_stall", 32'(CPU_Stall), 32'd0);
      RST = 1'b0;
      step();

      for (int k = 0; k < 17; k++) begin
         drive(vt[k].st, vt[k].sa, vt[k].sd, vt[k].ld, vt[k].la);
         @(negedge CLK);
         check($sformatf("v%0d_stall", k), 32'(CPU_Stall), 32'(vt[k].e_stall));
         check($sformatf("v%0d_we", k), 32'(DM_Write_Enable_Flag), 32'(vt[k].e_we));
         check($sformatf("v%0d_addr", k), DM_Input_Address, vt[k].e_addr);
         check($sformatf("v%0d_count", k), 32'(SB_Count), 32'(vt[k].e_count));
         check($sformatf("v%0d_empty", k), 32'(SB_Empty), 32'(vt[k].e_empty));
         if (vt[k].e_we) check($sformatf("v%0d_wdata", k), DM_Data_To_Write, vt[k].e_wdata);
         if (vt[k].chk_ld) check($sformatf("v%0d_ldata", k), CPU_Load_Data, vt[k].e_ld);
         step();
      end
      idle();
      check("mem5_after_drain", mem[5], 32'hAAAA5555);
      check("mem10_after_drain", mem[10], 32'h10);

`ifdef STORE_BUFFER_FWD_EN
      // Youngest buffered copy is forwarded while both stores are pending.
      drive(1, 7, 32'h11, 1, 50);
      step();
      drive(1, 7, 32'h22, 1, 50);
      step();
      drive(0, 0, 0, 1, 7);
      @(negedge CLK);
      check("fwd_ldata", CPU_Load_Data, 32'h22);
      check("fwd_stall", 32'(CPU_Stall), 32'd0);
      check("fwd_we", 32'(DM_Write_Enable_Flag), 32'd0);
      check("fwd_count", 32'(SB_Count), 32'd2);
      step();
      idle();
      step(); step(); step();
      check("fwd_mem7", mem[7], 32'h22);
      check("fwd_empty", 32'(SB_Empty), 32'd1);
`else
      // Load hitting a buffered address stalls one cycle while the drain writes it.
      drive(1, 3, 32'h33, 0, 0);
      step();
      drive(0, 0, 0, 1, 3);
      @(negedge CLK);
      check("haz_stall", 32'(CPU_Stall), 32'd1);
      check("haz_we", 32'(DM_Write_Enable_Flag), 32'd1);
      check("haz_addr", DM_Input_Address, 32'd3);
      check("haz_wdata", DM_Data_To_Write, 32'h33);
      step();
      @(negedge CLK);
      check("haz_stall_clear", 32'(CPU_Stall), 32'd0);
      check("haz_we_clear", 32'(DM_Write_Enable_Flag), 32'd0);
      check("haz_ldata", CPU_Load_Data, 32'h33);
      step();
      idle();
      step();
`endif

      // Mid-run reset with three entries buffered after one drain.
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'(30 + i), 32'(1 + i), 1, 40);
         step();
      end
      idle();
      step();
      @(negedge CLK);
      check("prerst_count", 32'(SB_Count), 32'd3);
      #1 RST = 1'b1;
      #1;
      check("midrst_empty", 32'(SB_Empty), 32'd1);
      check("midrst_count", 32'(SB_Count), 32'd0);
      check("midrst_we", 32'(DM_Write_Enable_Flag), 32'd0);
      check("midrst_stall", 32'(CPU_Stall), 32'd0);
      step();
      RST = 1'b0;
      step(); step(); step();
      check("midrst_mem30", mem[30], 32'd1);
      check("midrst_mem31", mem[31], 32'd0);
      check("midrst_mem33", mem[33], 32'd0);
      check("midrst_still_empty", 32'(SB_Empty), 32'd1);

      // Wrap-around: ten stores with a concurrent load every third cycle, scoreboarded.
      sb_on   = 1'b1;
      max_cnt = 0;
      begin
         int i;
         int cyc;
         i   = 0;
         cyc = 0;
         while (i < 10 && cyc < 100) begin
            drive(1, 32'(i), 32'hC0DE0000 + 32'(i), (cyc % 3) == 2, 60);
            @(negedge CLK);
            if (int'(SB_Count) > max_cnt) max_cnt = int'(SB_Count);
            if (!CPU_Stall) begin
               exp_q.push_back({32'(i), 32'hC0DE0000 + 32'(i)});
               i++;
            end
            step();
            cyc++;
         end
         check("wrap_all_accepted", 32'(i), 32'd10);
      end
      idle();
      for (int w = 0; w < 20 && !SB_Empty; w++) step();
      step();
      sb_on = 1'b0;
      check("wrap_drained", 32'(SB_Empty), 32'd1);
      check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
      check("wrap_max_count_le4", 32'(max_cnt <= 4), 32'd1);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("wrap_mem%0d", i), mem[i], 32'hC0DE0000 + 32'(i));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
